// File: rtl/cache_mul10_arb.sv
// rtl/cache_mul10_arb.sv - round-robin shared multiply-by-10 unit with per-requester response buffers
module cache_mul10_arb #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*16-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ*20-1:0] rsp_data,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic              busy,
  output logic [15:0]       issue_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   last_grant;
  logic            s1_valid;
  logic [IW-1:0]   s1_id;
  logic [19:0]     s1_prod;
  logic [19:0]     buf_data [NREQ];

  logic [NREQ-1:0] in_flight;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_id;
  logic            grant_any;
  logic [19:0]     operand;
  logic [19:0]     product;

  // A requester may not issue again while its previous operand sits in s1;
  // a full buffer only blocks it if the buffer is not being drained this cycle.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < NREQ; i++) begin
      in_flight[i] = s1_valid && (s1_id == IW'(i));
    end
    eligible = req_valid & ~in_flight & (~rsp_valid | rsp_ready);
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(last_grant) + 1 + k) % NREQ;
      if (!grant_any && eligible[idx]) begin
        grant_any   = 1'b1;
        grant_id    = idx[IW-1:0];
        grant[idx]  = 1'b1;
      end
    end
  end

  // Select the granted operand and form x*10 as x*8 + x*2.
  always_comb begin
    operand   = {4'b0000, req_data[16*int'(grant_id) +: 16]};
    product   = (operand << 3) + (operand << 1);
    req_ready = rst ? '0 : grant;
  end

  // Shared stage register plus arbitration pointer and accept counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_prod    <= '0;
      last_grant <= IW'(NREQ - 1);
      issue_cnt  <= '0;
    end else begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_id      <= grant_id;
        s1_prod    <= product;
        last_grant <= grant_id;
        issue_cnt  <= issue_cnt + 16'd1;
      end
    end
  end

  // Response buffers: a new result from s1 wins over a same-edge drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      for (int i = 0; i < NREQ; i++) begin
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (s1_valid && (s1_id == IW'(i))) begin
          rsp_valid[i] <= 1'b1;
          buf_data[i]  <= s1_prod;
        end else if (rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Flatten buffers onto the packed result bus and derive busy.
  always_comb begin
    rsp_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_data[20*i +: 20] = buf_data[i];
    end
    busy = s1_valid | (|rsp_valid);
  end

endmodule

// File: tb/tb_cache_mul10_arb.sv
// tb/tb_cache_mul10_arb.sv - scoreboard bench for cache_mul10_arb
module tb_cache_mul10_arb;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*16-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [N*20-1:0] rsp_data;
  logic [N-1:0]  rsp_ready;
  logic          busy;
  logic [15:0]   issue_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_infl [N];
  bit          m_buf  [N];
  int          m_last;
  logic [15:0] m_cnt;
  logic [19:0] exp_q [N][$];

  cache_mul10_arb #(.NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: compares DUT against the model each cycle, then advances the model
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {28'b0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_issue_cnt", {16'b0, issue_cnt}, 32'd0);
      chk("rst_rsp_data", {31'b0, |rsp_data}, 32'd0);
      for (int i = 0; i < N; i++) begin
        m_infl[i] = 1'b0;
        m_buf[i]  = 1'b0;
        exp_q[i].delete();
      end
      m_last = N - 1;
      m_cnt  = 16'd0;
    end else begin
      int g;
      logic [N-1:0] exp_rdy, exp_vld;
      bit any;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_last + 1 + k) % N;
        if (g < 0 && req_valid[idx] && !m_infl[idx] && (!m_buf[idx] || rsp_ready[idx]))
          g = idx;
      end
      exp_rdy = '0;
      exp_vld = '0;
      any = 1'b0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      for (int i = 0; i < N; i++) begin
        exp_vld[i] = m_buf[i];
        any = any | m_buf[i] | m_infl[i];
      end
      chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
      chk("rsp_valid", {28'b0, rsp_valid}, {28'b0, exp_vld});
      chk("busy", {31'b0, busy}, {31'b0, any});
      chk("issue_cnt", {16'b0, issue_cnt}, {16'b0, m_cnt});
      for (int i = 0; i < N; i++) begin
        if (m_buf[i]) begin
          if (exp_q[i].size() > 0)
            chk($sformatf("rsp_data%0d", i), {12'b0, rsp_data[20*i +: 20]}, {12'b0, exp_q[i][0]});
          else
            chk($sformatf("scoreboard_empty%0d", i), 32'd1, 32'd0);
        end
      end
      // advance model across the coming edge
      for (int i = 0; i < N; i++) begin
        if (m_buf[i] && rsp_ready[i]) begin
          m_buf[i] = 1'b0;
          void'(exp_q[i].pop_front());
        end
        if (m_infl[i]) begin
          m_infl[i] = 1'b0;
          m_buf[i]  = 1'b1;
        end
      end
      if (g >= 0) begin
        int d;
        d = int'(req_data[16*g +: 16]);
        exp_q[g].push_back(20'(d * 10));
        m_infl[g] = 1'b1;
        m_last    = g;
        m_cnt     = m_cnt + 16'd1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '0;

    // single requester 0, operand 1234
    do_reset();
    req_valid = 4'b0001;
    req_data[15:0] = 16'd1234;
    #1;
    chk("r031_ready", {28'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("r031_not_yet", {31'b0, rsp_valid[0]}, 32'd0);
    @(posedge clk);
    #1;
    chk("r031_valid", {31'b0, rsp_valid[0]}, 32'd1);
    chk("r031_data", {12'b0, rsp_data[19:0]}, 32'd12340);
    chk("r031_cnt", {16'b0, issue_cnt}, 32'd1);

    // all four requesters from reset: grants in order 0,1,2,3
    do_reset();
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    for (int k = 0; k < N; k++) begin
      #1;
      chk($sformatf("r032_grant%0d", k), {28'b0, req_ready}, 32'd1 << k);
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    repeat (4) @(posedge clk);

    // extreme operands
    do_reset();
    req_valid = 4'b0011;
    req_data[15:0]  = 16'hFFFF;
    req_data[31:16] = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("r033_max", {12'b0, rsp_data[19:0]}, 32'h9FFF6);
    chk("r033_zero_vld", {31'b0, rsp_valid[1]}, 32'd1);
    chk("r033_zero", {12'b0, rsp_data[39:20]}, 32'd0);

    // blocked full buffer, then same-cycle drain and re-accept
    do_reset();
    req_valid = 4'b0001;
    req_data[15:0] = 16'd100;
    @(posedge clk);
    #1;
    req_data[15:0] = 16'd200;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("r034_blocked", {31'b0, req_ready[0]}, 32'd0);
      chk("r034_hold", {12'b0, rsp_data[19:0]}, 32'd1000);
    end
    rsp_ready = 4'b0001;
    #1;
    chk("r034_reaccept", {28'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = '0;
    @(posedge clk);
    #1;
    chk("r034_new_vld", {31'b0, rsp_valid[0]}, 32'd1);
    chk("r034_new_data", {12'b0, rsp_data[19:0]}, 32'd2000);
    chk("r034_cnt", {16'b0, issue_cnt}, 32'd2);

    // reset one cycle after an accept
    do_reset();
    req_valid = 4'b0001;
    req_data[15:0] = 16'd5;
    rsp_ready = 4'b0001;
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("r035_vld", {28'b0, rsp_valid}, 32'd0);
    chk("r035_busy", {31'b0, busy}, 32'd0);
    chk("r035_cnt", {16'b0, issue_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("r035_no_stale", {28'b0, rsp_valid}, 32'd0);
    end

    // randomized traffic
    do_reset();
    repeat (3000) begin
      @(posedge clk);
      #1;
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 5))
          0: req_data[16*i +: 16] = 16'hFFFF;
          1: req_data[16*i +: 16] = 16'h0000;
          default: req_data[16*i +: 16] = 16'($urandom);
        endcase
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 4'hF;
    repeat (4) @(posedge clk);

    // issue counter wrap
    do_reset();
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    begin
      bit reached;
      reached = 1'b0;
      for (int c = 0; c < 70000 && !reached; c++) begin
        @(posedge clk);
        #1;
        req_data = {$urandom, $urandom};
        if (m_cnt == 16'hFFFF) reached = 1'b1;
      end
      chk("r036_reached", {31'b0, reached}, 32'd1);
      if (reached) begin
        chk("r036_pre", {16'b0, issue_cnt}, 32'hFFFF);
        @(posedge clk);
        #1;
        chk("r036_wrap", {16'b0, issue_cnt}, 32'd0);
      end
    end
    req_valid = '0;
    repeat (4) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_mul10_arb.md
CACHE_MUL10_ARB -- requirements
Module: cache_mul10_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing the multiply-by-10 unit, range 2..8.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ bits: per-requester operand valid.
REQ-006 SHALL have port req_data, input, NREQ*16 bits: requester i operand on bits [16i+15:16i], unsigned.
REQ-007 SHALL have port req_ready, output, NREQ bits: per-requester accept, one-hot or zero.
REQ-008 SHALL have port rsp_valid, output, NREQ bits: per-requester result valid.
REQ-009 SHALL have port rsp_data, output, NREQ*20 bits: requester i result on bits [20i+19:20i].
REQ-010 SHALL have port rsp_ready, input, NREQ bits: per-requester result consumed.
REQ-011 SHALL have port busy, output, 1 bit: a multiply is in flight or any rsp_valid is high.
REQ-012 SHALL have port issue_cnt, output, 16 bits: count of accepted operands.

Function
REQ-013 SHALL contain one shared multiply stage: a registered product = operand*10, 20 bits wide and zero-extended; no overflow is possible (max 655350).
REQ-014 SHALL mark requester i eligible when: req_valid[i]; no in-flight operation for i; and rsp_valid[i]==0 or rsp_ready[i]==1 in the same cycle.
REQ-015 SHALL grant at most one eligible requester per cycle, using round-robin.
REQ-016 SHALL search round-robin from (last_grant+1) mod NREQ; the pointer updates only on a grant.
REQ-017 SHALL drive req_ready combinationally: high only for the granted index. An accept is req_valid[i] & req_ready[i].
REQ-018 SHALL keep an accept at edge T in stage register s1 (valid, id, product); the result is written into response buffer id at edge T+1.
REQ-019 SHALL hold rsp_valid[id] high from the cycle after edge T+1, i.e., a 2-cycle accept-to-valid latency.
REQ-020 SHALL hold rsp_valid[i] and rsp_data[i] stable until rsp_ready[i] is high; then clear rsp_valid[i] on that edge, unless a new result for i is written on the same edge.
REQ-021 SHALL give a same-edge write of a new result to buffer i priority over the drain: rsp_valid stays 1 and rsp_data takes the new value.
REQ-022 SHALL allow s1 to accept a new operand every cycle; full throughput is 1 result/cycle across distinct requesters.
REQ-023 SHALL limit any single requester to at most 1 accept per 2 cycles, because of the in-flight rule.
REQ-024 SHALL ignore req_data of non-granted requesters; rsp_ready for a buffer with rsp_valid==0 has no effect.
REQ-025 SHALL increment issue_cnt by 1 per accept, wrapping from 16'hFFFF to 16'h0000.
REQ-026 SHALL drive busy = s1_valid | (|rsp_valid).

Reset
REQ-027 SHALL, while rst is high and asynchronously, clear: s1_valid, all rsp_valid, issue_cnt, and last_grant. last_grant resets to NREQ-1, so requester 0 has first priority.
REQ-028 SHALL reset rsp_data and the s1 product to 0; req_ready is 0 while rst is high.
REQ-029 SHALL discard an operation in flight when rst is asserted; no stale result appears after rst deasserts.
REQ-030 SHALL allow accepts from the first rising edge after rst deasserts.

Verification
REQ-031 SHALL cover: single requester 0 with req_data0=16'd1234 accepted at edge T -> rsp_valid[0] high after edge T+1, rsp_data0=20'd12340, issue_cnt=1.
REQ-032 SHALL cover: all 4 req_valid high from reset with rsp_ready all 1 -> grants 0,1,2,3 on consecutive cycles; results 2 cycles after each grant.
REQ-033 SHALL cover: req_data=16'hFFFF -> rsp_data=20'h9FFF6 (655350); req_data=0 -> rsp_data=0.
REQ-034 SHALL cover: requester 0 always valid with rsp_ready[0]=0 -> one accept, then req_ready[0]=0. Raising rsp_ready[0] -> next accept in that same cycle, and the result overwrites the buffer with no loss.
REQ-035 SHALL cover: rst asserted one cycle after an accept -> rsp_valid=0, busy=0, issue_cnt=0 immediately; no response appears after release.
REQ-036 SHALL cover: issue_cnt preloaded via 65535 accepts -> the next accept gives issue_cnt=0.
